// File: rtl/bitcnt_pkg.sv
// rtl/bitcnt_pkg.sv - shared types and helpers for the sequential bit-count unit
package bitcnt_pkg;

  typedef enum logic [2:0] {
    FN_CLZ   = 3'b000,
    FN_CLZW  = 3'b001,
    FN_CTZ   = 3'b010,
    FN_CTZW  = 3'b011,
    FN_CPOP  = 3'b100,
    FN_CPOPW = 3'b101
  } func_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  function automatic logic is_word(input logic [2:0] func);
    return (func == FN_CLZW) || (func == FN_CTZW) || (func == FN_CPOPW);
  endfunction

  function automatic logic is_clz(input logic [2:0] func);
    return (func == FN_CLZ) || (func == FN_CLZW);
  endfunction

  function automatic logic is_cpop(input logic [2:0] func);
    return (func == FN_CPOP) || (func == FN_CPOPW);
  endfunction

  function automatic logic is_reserved(input logic [2:0] func);
    return func[2:1] == 2'b11;
  endfunction

  // Counter must hold the full width itself (all-zero clz, all-ones cpop).
  function automatic int cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/bitcnt_slice.sv
// rtl/bitcnt_slice.sv - popcount, trailing-zero count and any-one flag of one chunk
module bitcnt_slice #(
  parameter int CHUNK = 8,
  parameter int SW    = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] slice,
  output logic [SW-1:0]    pop,
  output logic [SW-1:0]    tz,
  output logic             has_one
);

  always_comb begin
    pop     = '0;
    tz      = '0;
    has_one = |slice;
    for (int i = 0; i < CHUNK; i++) begin
      pop = pop + SW'(slice[i]);
    end
    // Scan downward so the lowest set bit wins.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (slice[i]) tz = SW'(i);
    end
  end

endmodule

// File: rtl/bitcnt_seq.sv
// rtl/bitcnt_seq.sv - multi-cycle clz/ctz/cpop unit scanning CHUNK bits per cycle
module bitcnt_seq #(
  parameter int XLEN       = 64,
  parameter int CHUNK      = 8,
  parameter int EARLY_TERM = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_data,
  input  logic [2:0]      din_func,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_data
);
  import bitcnt_pkg::*;

  localparam int CNT_W = cnt_w(XLEN);
  localparam int CL_W  = $clog2(XLEN / CHUNK) + 1;
  localparam int SW    = $clog2(CHUNK) + 1;
  localparam logic [CL_W-1:0] LEFT_FULL = CL_W'(XLEN / CHUNK);
  localparam logic [CL_W-1:0] LEFT_WORD = CL_W'(32 / CHUNK);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CL_W-1:0]   left_q, left_d;
  logic              found_q, found_d;
  logic              cpop_q, cpop_d;

  logic [XLEN-1:0]   norm, rev_full;
  logic [31:0]       rev_word;
  logic [SW-1:0]     sl_pop, sl_tz;
  logic              sl_has_one;
  logic              accept;

  bitcnt_slice #(
    .CHUNK (CHUNK),
    .SW    (SW)
  ) u_slice (
    .slice   (shreg_q[CHUNK-1:0]),
    .pop     (sl_pop),
    .tz      (sl_tz),
    .has_one (sl_has_one)
  );

  assign din_ready  = !reset && ((state_q == S_IDLE) || ((state_q == S_DONE) && dout_ready));
  assign accept     = din_valid && din_ready;
  assign dout_valid = (state_q == S_DONE);
  assign dout_data  = dout_valid ? {{(XLEN - CNT_W){1'b0}}, count_q} : '0;

  // clz is turned into ctz by reversing the active field, so the datapath only scans LSB-first.
  always_comb begin
    rev_full = '0;
    rev_word = '0;
    norm     = '0;
    for (int i = 0; i < XLEN; i++) rev_full[i] = din_data[XLEN-1-i];
    for (int i = 0; i < 32; i++)   rev_word[i] = din_data[31-i];
    if (is_word(din_func)) begin
      norm[31:0] = is_clz(din_func) ? rev_word : din_data[31:0];
    end else begin
      norm = is_clz(din_func) ? rev_full : din_data;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    left_d  = left_q;
    found_d = found_q;
    cpop_d  = cpop_q;

    case (state_q)
      S_BUSY: begin
        if (cpop_q) begin
          count_d = count_q + CNT_W'(sl_pop);
        end else if (!found_q) begin
          if (sl_has_one) begin
            count_d = count_q + CNT_W'(sl_tz);
            found_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(CHUNK);
          end
        end
        shreg_d = shreg_q >> CHUNK;
        left_d  = left_q - CL_W'(1);
        if ((left_q == CL_W'(1)) || (found_d && (EARLY_TERM != 0))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (dout_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Accept may coincide with the result handoff out of DONE.
    if (accept) begin
      shreg_d = norm;
      count_d = '0;
      found_d = 1'b0;
      cpop_d  = is_cpop(din_func);
      left_d  = is_word(din_func) ? LEFT_WORD : LEFT_FULL;
      state_d = is_reserved(din_func) ? S_DONE : S_BUSY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      left_q  <= '0;
      found_q <= 1'b0;
      cpop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      left_q  <= left_d;
      found_q <= found_d;
      cpop_q  <= cpop_d;
    end
  end

endmodule

// File: tb/tb_bitcnt_seq.sv
// tb/tb_bitcnt_seq.sv - scoreboard bench for bitcnt_seq (XLEN=64, CHUNK=8)
module tb_bitcnt_seq;

  logic        clock;
  logic        reset;
  logic        din_valid, din_ready;
  logic [63:0] din_data;
  logic [2:0]  din_func;
  logic        dout_valid, dout_ready;
  logic [63:0] dout_data;

  logic        ne_din_valid, ne_din_ready;
  logic [63:0] ne_din_data;
  logic [2:0]  ne_din_func;
  logic        ne_dout_valid;
  logic [63:0] ne_dout_data;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  bitcnt_seq #(.XLEN(64), .CHUNK(8), .EARLY_TERM(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_func   (din_func),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
  );

  bitcnt_seq #(.XLEN(64), .CHUNK(8), .EARLY_TERM(0)) dut_ne (
    .clock      (clock),
    .reset      (reset),
    .din_valid  (ne_din_valid),
    .din_ready  (ne_din_ready),
    .din_data   (ne_din_data),
    .din_func   (ne_din_func),
    .dout_valid (ne_dout_valid),
    .dout_ready (1'b1),
    .dout_data  (ne_dout_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input logic [2:0] f, input logic [63:0] d,
                                output logic [63:0] res, output int lat);
    int n;
    int c;
    bit hit;
    logic [63:0] v;
    n   = f[0] ? 32 : 64;
    v   = f[0] ? {32'h0, d[31:0]} : d;
    c   = 0;
    hit = 0;
    case (f)
      3'd0, 3'd1: for (int i = 63; i >= 0; i--)
        if (i < n && !hit) begin if (v[i]) hit = 1; else c++; end
      3'd2, 3'd3: for (int i = 0; i < 64; i++)
        if (i < n && !hit) begin if (v[i]) hit = 1; else c++; end
      3'd4, 3'd5: for (int i = 0; i < 64; i++) c += int'(v[i]);
      default: c = 0;
    endcase
    if (f[2:1] == 2'b11)      lat = 1;
    else if (f[2:1] == 2'b10) lat = 1 + n / 8;
    else if (c < n)           lat = 2 + c / 8;
    else                      lat = 1 + n / 8;
    res = 64'(c);
  endfunction

  task automatic push_exp(input logic [2:0] f, input logic [63:0] d);
    logic [63:0] r;
    int l;
    model(f, d, r, l);
    exp_q.push_back(r);
    lat_q.push_back(l);
  endtask

  // Returns just after the accepting edge.
  task automatic drive_req(input logic [2:0] f, input logic [63:0] d);
    int n;
    @(negedge clock);
    din_func  = f;
    din_data  = d;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!din_ready) begin
      errors++;
      $display("FAIL accept_timeout: din_ready=%0b required 1", din_ready);
    end
    @(posedge clock);
    #1 din_valid = 1'b0;
  endtask

  task automatic expect_result(input string name);
    logic [63:0] e;
    int el;
    int lat;
    e   = exp_q.pop_front();
    el  = lat_q.pop_front();
    lat = 1;
    @(negedge clock);
    while (!dout_valid && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (!dout_valid) begin
      errors++;
      $display("FAIL %s_timeout: dout_valid=%0b required 1", name, dout_valid);
    end else begin
      checks++;
      if (dout_data !== e) begin
        errors++;
        $display("FAIL %s_data: got %0d required %0d", name, dout_data, e);
      end
      checks++;
      if (lat !== el) begin
        errors++;
        $display("FAIL %s_latency: got %0d required %0d", name, lat, el);
      end
    end
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [63:0] d);
    push_exp(f, d);
    drive_req(f, d);
    expect_result(name);
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    din_func   = '0;
    dout_ready = 1'b1;
    ne_din_valid = 1'b0;
    ne_din_data  = '0;
    ne_din_func  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 64'h0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b data=%0h ready=%0b required 0 0 0",
               dout_valid, dout_data, din_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b required 1", din_ready);
    end
  endtask

  task automatic test_plan_vectors;
    run("cpop_mixed", 3'b100, 64'hFFFF_0000_0000_00FF);
    run("ctz_bit16",  3'b010, 64'h0000_0000_0001_0000);
    run("clzw_upper", 3'b001, 64'hDEAD_BEEF_0000_0001);
    run("clz_zero",   3'b000, 64'h0);
    run("ctzw_zero",  3'b011, 64'h0);
    run("ctz_zero",   3'b010, 64'h0);
    run("cpop_ones",  3'b100, 64'hFFFF_FFFF_FFFF_FFFF);
    run("cpopw_ones", 3'b101, 64'hFFFF_FFFF_FFFF_FFFF);
    run("clz_msb",    3'b000, 64'h8000_0000_0000_0000);
    run("reserved6",  3'b110, 64'h1234_5678_9ABC_DEF0);
    run("reserved7",  3'b111, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic test_no_early_term;
    int lat;
    @(negedge clock);
    ne_din_func  = 3'b010;
    ne_din_data  = 64'h0000_0000_0001_0000;
    ne_din_valid = 1'b1;
    checks++;
    if (ne_din_ready !== 1'b1) begin
      errors++;
      $display("FAIL ne_ready: got %0b required 1", ne_din_ready);
    end
    @(posedge clock);
    #1 ne_din_valid = 1'b0;
    lat = 1;
    @(negedge clock);
    while (!ne_dout_valid && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (ne_dout_data !== 64'd16 || lat != 9) begin
      errors++;
      $display("FAIL ne_ctz: data=%0d latency=%0d required 16 and 9", ne_dout_data, lat);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    dout_ready = 1'b0;
    push_exp(3'b100, 64'hF0);
    drive_req(3'b100, 64'hF0);
    expect_result("bp_first");
    din_func  = 3'b100;
    din_data  = 64'h3;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (dout_valid !== 1'b1 || dout_data !== 64'd4 || din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%0b data=%0d ready=%0b required 1 4 0",
                 dout_valid, dout_data, din_ready);
      end
    end
    @(negedge clock);
    dout_ready = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handoff_ready: got %0b required 1", din_ready);
    end
    push_exp(3'b100, 64'h3);
    @(posedge clock);
    #1 din_valid = 1'b0;
    expect_result("bp_second");
    n = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    drive_req(3'b100, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: valid=%0b ready=%0b required 0 0", dout_valid, din_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    dout_ready = 1'b0;
    drive_req(3'b100, 64'hFFFF);
    n = 0;
    while (!dout_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_done: valid=%0b data=%0h required 0 0", dout_valid, dout_data);
    end
    @(negedge clock);
    reset = 1'b0;
    dout_ready = 1'b1;
    run("post_reset_cpop", 3'b100, 64'h1);
  endtask

  task automatic test_random;
    logic [63:0] d;
    logic [2:0]  f;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      if (i % 2 == 0) d = 64'h1 << $urandom_range(0, 63);
      else            d = {$urandom, $urandom};
      run("random", f, d);
    end
  endtask

  initial begin
    test_reset;
    test_plan_vectors;
    test_no_early_term;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
